// File: rtl/mac_pipe_n.sv
`default_nettype none
// ============================================================================
// Module   : mac_pipe_n
// Purpose  : Counted multiply-accumulate for the 2D convolution datapath.
//            Products go through a PIPES-deep register pipeline and are
//            summed into an OUTW-bit signed accumulator. A window is opened
//            by init_acc and closes after num_terms valid products have been
//            added; out_valid then pulses for one cycle alongside the final
//            sum. An optional clamp replaces two's-complement wrap on
//            overflow, and a sticky overflow flag covers the current window.
// Ports    : clk         - rising-edge clock
//            reset       - synchronous active-high, clears all state
//            input0/1    - signed INW-bit operands
//            input_valid - operands valid this cycle
//            init_value  - signed INW-bit seed, sign-extended on init_acc
//            init_acc    - opens a new window (load seed, latch num_terms)
//            num_terms   - products per window, sampled on init_acc
//            out         - signed OUTW-bit accumulator
//            out_valid   - one-cycle pulse with the completed sum
//            overflow    - sticky range-exceeded flag for the current window
// Revision : 1.0 - initial release
// ============================================================================
module mac_pipe_n #(
  parameter int INW   = 12,
  parameter int OUTW  = 48,
  parameter int PIPES = 2,
  parameter int SAT   = 0,
  parameter int CNTW  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [INW-1:0]  input0,
  input  logic signed [INW-1:0]  input1,
  input  logic                   input_valid,
  input  logic signed [INW-1:0]  init_value,
  input  logic                   init_acc,
  input  logic [CNTW-1:0]        num_terms,
  output logic signed [OUTW-1:0] out,
  output logic                   out_valid,
  output logic                   overflow
);

  localparam int PW = 2 * INW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state;
  logic signed [PW-1:0]   prod_pipe [PIPES];
  logic [PIPES-1:0]       vld_pipe;
  logic [CNTW-1:0]        count;
  logic [CNTW-1:0]        limit;

  logic signed [PW-1:0]   mult;
  logic signed [PW-1:0]   arr_prod;
  logic                   arr_vld;
  logic signed [OUTW:0]   sum;
  logic                   sum_ovf;
  logic signed [OUTW-1:0] acc_next;
  logic [CNTW-1:0]        count_next;

  // Multiply at full product width; both operands are signed so the
  // multiplication sign-extends them to PW bits.
  assign mult     = PW'(input0) * PW'(input1);
  assign arr_prod = prod_pipe[PIPES-1];
  assign arr_vld  = vld_pipe[PIPES-1];

  // Product pipeline: free-running, only reset can clear it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPES; i++) begin
        prod_pipe[i] <= '0;
      end
      vld_pipe <= '0;
    end else begin
      prod_pipe[0] <= mult;
      vld_pipe[0]  <= input_valid;
      for (int i = 1; i < PIPES; i++) begin
        prod_pipe[i] <= prod_pipe[i-1];
        vld_pipe[i]  <= vld_pipe[i-1];
      end
    end
  end

  // One guard bit: the sum cannot exceed OUTW+1 bits since OUTW >= PW.
  // Overflow shows up as disagreement between the guard and the OUTW sign.
  always_comb begin
    sum        = {out[OUTW-1], out} + {{(OUTW + 1 - PW){arr_prod[PW-1]}}, arr_prod};
    sum_ovf    = sum[OUTW] ^ sum[OUTW-1];
    acc_next   = sum[OUTW-1:0];
    count_next = count + 1'b1;
    if ((SAT != 0) && sum_ovf) begin
      // Guard bit holds the true sign: negative -> min, positive -> max.
      acc_next = sum[OUTW] ? {1'b1, {(OUTW-1){1'b0}}} : {1'b0, {(OUTW-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      out       <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      count     <= '0;
      limit     <= '0;
    end else begin
      out_valid <= 1'b0;
      if (init_acc) begin
        // A product arriving this same cycle is discarded, not counted.
        out      <= {{(OUTW-INW){init_value[INW-1]}}, init_value};
        limit    <= num_terms;
        count    <= '0;
        overflow <= 1'b0;
        if (num_terms == '0) begin
          state     <= ST_DONE;
          out_valid <= 1'b1;
        end else begin
          state <= ST_ACC;
        end
      end else begin
        case (state)
          ST_ACC: begin
            if (arr_vld) begin
              out   <= acc_next;
              count <= count_next;
              if (sum_ovf) begin
                overflow <= 1'b1;
              end
              if (count_next == limit) begin
                state     <= ST_DONE;
                out_valid <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            // Hold the completed sum; late products are ignored.
          end
          default: begin
            // IDLE: products reaching the accumulator are dropped.
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_pipe_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_pipe_n
// Purpose  : Self-checking bench for mac_pipe_n. Three instances share one
//            stimulus stream: default (OUTW 48, wrap, PIPES 2), OUTW 24 with
//            clamp and PIPES 1, OUTW 24 with wrap and PIPES 4. A behavioural
//            window model per instance pushes expected completions into a
//            scoreboard queue; a monitor pops them on out_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_pipe_n;

  typedef struct {
    longint v;
    bit     o;
    int     c;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] input0, input1, init_value;
  logic        input_valid, init_acc;
  logic [7:0]  num_terms;

  logic [47:0] out_a;
  logic [23:0] out_b, out_c;
  logic        ov_a, ov_b, ov_c;
  logic        of_a, of_b, of_c;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // history of what was issued each cycle
  longint hist_p [8192];
  bit     hist_v [8192];
  bit     hist_r [8192];

  // behavioural model state per instance (0 idle, 1 accumulating, 2 done)
  int     pipes [3] = '{2, 1, 4};
  int     outw  [3] = '{48, 24, 24};
  bit     sat   [3] = '{1'b0, 1'b1, 1'b0};
  longint m_out [3];
  bit     m_ovf [3];
  int     m_st  [3];
  int     m_cnt [3];
  int     m_lim [3];

  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  mac_pipe_n #(.INW(12), .OUTW(48), .PIPES(2), .SAT(0), .CNTW(8)) dut_a (
    .clk(clk), .reset(reset), .input0(input0), .input1(input1),
    .input_valid(input_valid), .init_value(init_value), .init_acc(init_acc),
    .num_terms(num_terms), .out(out_a), .out_valid(ov_a), .overflow(of_a));

  mac_pipe_n #(.INW(12), .OUTW(24), .PIPES(1), .SAT(1), .CNTW(8)) dut_b (
    .clk(clk), .reset(reset), .input0(input0), .input1(input1),
    .input_valid(input_valid), .init_value(init_value), .init_acc(init_acc),
    .num_terms(num_terms), .out(out_b), .out_valid(ov_b), .overflow(of_b));

  mac_pipe_n #(.INW(12), .OUTW(24), .PIPES(4), .SAT(0), .CNTW(8)) dut_c (
    .clk(clk), .reset(reset), .input0(input0), .input1(input1),
    .input_valid(input_valid), .init_value(init_value), .init_acc(init_acc),
    .num_terms(num_terms), .out(out_c), .out_valid(ov_c), .overflow(of_c));

  function automatic longint get_out(int k);
    case (k)
      0:       return longint'($signed(out_a));
      1:       return longint'($signed(out_b));
      default: return longint'($signed(out_c));
    endcase
  endfunction

  function automatic bit get_vld(int k);
    case (k)
      0:       return ov_a;
      1:       return ov_b;
      default: return ov_c;
    endcase
  endfunction

  function automatic bit get_ovf(int k);
    case (k)
      0:       return of_a;
      1:       return of_b;
      default: return of_c;
    endcase
  endfunction

  task automatic push(int k, exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qfront(int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(int k);
    case (k)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic check(string name, int k, longint got, longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", name, k, cyc, got, want);
    end
  endtask

  // Reference model: advance every instance by one clock using the rules
  // of a window (seed, count products, finish, ignore extras).
  always @(posedge clk) begin
    int c;
    c = cyc;
    hist_v[c] = input_valid;
    hist_r[c] = reset;
    hist_p[c] = longint'($signed(input0)) * longint'($signed(input1));
    for (int k = 0; k < 3; k++) begin
      longint mx, mn, sum;
      bit     arr;
      int     t;
      exp_t   e;
      mx = (longint'(1) << (outw[k] - 1)) - 1;
      mn = -(longint'(1) << (outw[k] - 1));
      t  = c - pipes[k];
      arr = 1'b0;
      if (t >= 0 && hist_v[t]) begin
        arr = 1'b1;
        for (int j = t; j <= c; j++) if (hist_r[j]) arr = 1'b0;
      end
      if (reset) begin
        m_out[k] = 0; m_ovf[k] = 0; m_st[k] = 0; m_cnt[k] = 0; m_lim[k] = 0;
      end else if (init_acc) begin
        m_out[k] = longint'($signed(init_value));
        m_lim[k] = int'(num_terms);
        m_cnt[k] = 0;
        m_ovf[k] = 1'b0;
        if (num_terms == 8'd0) begin
          m_st[k] = 2;
          e.v = m_out[k]; e.o = m_ovf[k]; e.c = c + 1;
          push(k, e);
        end else begin
          m_st[k] = 1;
        end
      end else if (m_st[k] == 1 && arr) begin
        sum = m_out[k] + hist_p[t];
        if (sum > mx) begin
          m_ovf[k] = 1'b1;
          m_out[k] = sat[k] ? mx : sum - (longint'(1) << outw[k]);
        end else if (sum < mn) begin
          m_ovf[k] = 1'b1;
          m_out[k] = sat[k] ? mn : sum + (longint'(1) << outw[k]);
        end else begin
          m_out[k] = sum;
        end
        m_cnt[k]++;
        if (m_cnt[k] == m_lim[k]) begin
          m_st[k] = 2;
          e.v = m_out[k]; e.o = m_ovf[k]; e.c = c + 1;
          push(k, e);
        end
      end
    end
    cyc = c + 1;
  end

  // Monitor: trace out/overflow every cycle and reconcile pulses with the
  // scoreboard.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      check("out_trace", k, get_out(k), m_out[k]);
      check("ovf_trace", k, longint'(get_ovf(k)), longint'(m_ovf[k]));
      while (qsize(k) > 0 && qfront(k).c < cyc) begin
        e = qfront(k);
        qpop(k);
        checks++;
        errors++;
        $display("FAIL missing_pulse dut%0d cyc %0d: got no out_valid expected pulse at cyc %0d", k, cyc, e.c);
      end
      if (get_vld(k)) begin
        if (qsize(k) == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_pulse dut%0d cyc %0d: got out_valid=1 expected 0", k, cyc);
        end else begin
          e = qfront(k);
          qpop(k);
          check("pulse_cycle", k, longint'(cyc), longint'(e.c));
          check("pulse_out", k, get_out(k), e.v);
          check("pulse_ovf", k, longint'(get_ovf(k)), longint'(e.o));
        end
      end
    end
  end

  task automatic drive(bit ia, int iv, int nt, bit v, int a, int b, bit r);
    init_acc    = ia;
    init_value  = iv[11:0];
    num_terms   = nt[7:0];
    input_valid = v;
    input0      = a[11:0];
    input1      = b[11:0];
    reset       = r;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; init_acc = 1'b0; init_value = '0; num_terms = '0;
    input_valid = 1'b0; input0 = '0; input1 = '0;
    repeat (3) @(negedge clk);
    check("reset_out", 0, longint'($signed(out_a)), 0);
    check("reset_valid", 0, longint'(ov_a), 0);
    check("reset_ovf", 0, longint'(of_a), 0);

    // basic window: 5 + 6 - 20 + 49 = 40
    drive(1'b1, 5, 3, 1'b1, 2, 3, 1'b0);
    drive(1'b0, 0, 0, 1'b1, -4, 5, 1'b0);
    drive(1'b0, 0, 0, 1'b1, 7, 7, 1'b0);
    idle(6);
    check("basic_sum", 0, longint'($signed(out_a)), 40);

    // product after completion is ignored; then a one-term window
    drive(1'b0, 0, 0, 1'b1, 10, 10, 1'b0);
    idle(6);
    check("drop_after_done", 0, longint'($signed(out_a)), 40);
    drive(1'b1, 0, 1, 1'b0, 0, 0, 1'b0);
    drive(1'b0, 0, 0, 1'b1, 3, 3, 1'b0);
    idle(6);
    check("one_term", 0, longint'($signed(out_a)), 9);

    // saturation / wrap at OUTW 24
    drive(1'b1, 0, 3, 1'b1, 2047, 2047, 1'b0);
    drive(1'b0, 0, 0, 1'b1, 2047, 2047, 1'b0);
    drive(1'b0, 0, 0, 1'b1, 2047, 2047, 1'b0);
    idle(7);
    check("sat_out", 1, longint'($signed(out_b)), 8388607);
    check("sat_ovf", 1, longint'(of_b), 1);
    check("wrap_out", 2, longint'($signed(out_c)), -4206589);
    check("wrap_ovf", 2, longint'(of_c), 1);
    check("wide_out", 0, longint'($signed(out_a)), 12570627);
    drive(1'b1, 0, 5, 1'b0, 0, 0, 1'b0);
    check("sat_ovf_clear", 1, longint'(of_b), 0);
    check("wrap_ovf_clear", 2, longint'(of_c), 0);

    // zero-term window completes immediately
    drive(1'b1, -7, 0, 1'b0, 0, 0, 1'b0);
    check("zero_out", 0, longint'($signed(out_a)), -7);
    check("zero_valid", 0, longint'(ov_a), 1);

    // collision: the (5,5) product reaches dut_a exactly with init_acc
    drive(1'b0, 0, 0, 1'b1, 5, 5, 1'b0);
    idle(1);
    drive(1'b1, 1, 2, 1'b0, 0, 0, 1'b0);
    drive(1'b0, 0, 0, 1'b1, 1, 1, 1'b0);
    drive(1'b0, 0, 0, 1'b1, 2, 2, 1'b0);
    idle(6);
    check("collision_sum", 0, longint'($signed(out_a)), 6);

    // reset with products in flight
    drive(1'b1, 0, 4, 1'b1, 3, 3, 1'b0);
    drive(1'b0, 0, 0, 1'b1, 3, 3, 1'b0);
    drive(1'b0, 0, 0, 1'b1, 3, 3, 1'b1);
    check("rst_mid_out", 0, longint'($signed(out_a)), 0);
    check("rst_mid_valid", 0, longint'(ov_a), 0);
    idle(6);
    check("rst_after_out", 2, longint'($signed(out_c)), 0);

    // randomized streaming windows, including back-to-back inits
    for (int i = 0; i < 800; i++) begin
      bit ia, v, r;
      int a, b;
      ia = ($urandom_range(0, 7) == 0);
      v  = ($urandom_range(0, 4) != 0);
      r  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, 1) ? 2047 : -2048;
        b = $urandom_range(0, 1) ? 2047 : -2048;
      end else begin
        a = int'($urandom_range(0, 4095)) - 2048;
        b = int'($urandom_range(0, 4095)) - 2048;
      end
      drive(ia, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 6)),
            v, a, b, r);
    end
    idle(10);

    for (int k = 0; k < 3; k++) check("queue_drained", k, longint'(qsize(k)), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_pipe_n.md
# mac_pipe_n

Parametrised, counted multiply-accumulate unit for the 2D convolution datapath. It is the successor to the two-stage MAC. Its additions:
- configurable multiplier pipeline depth
- optional saturation
- sticky overflow detection
- a runtime term counter that flags when a full window of `num_terms` products (e.g. K×K taps) has been summed

One instance computes one output pixel per accumulation window and sits between the convolution controller and the output writer.

## Interface
Parameters:
- `INW`, 12, signed operand width
- `OUTW`, 48, signed accumulator/output width; must satisfy OUTW ≥ 2·INW
- `PIPES`, 2, multiplier register stages, ≥ 1
- `SAT`, 0, 0 = wrap on overflow, 1 = clamp to OUTW signed max/min
- `CNTW`, 8, width of the term counter and `num_terms`

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; clears all state
- `input0`, `input1`  in  INW  signed operands
- `input_valid`  in  1  operands valid this cycle
- `init_value`  in  INW  signed; sign-extended to OUTW and loaded on `init_acc`
- `init_acc`  in  1  starts a new window
- `num_terms`  in  CNTW  unsigned products per window; sampled only on `init_acc`
- `out`  out  OUTW  signed accumulator
- `out_valid`  out  1  one-cycle pulse when the window completes
- `overflow`  out  1  sticky; set on any accumulate that exceeded the OUTW signed range in the current window

## Operation
Datapath:
- The product `input0*input1` (2·INW bits, signed) enters a PIPES-deep register pipeline every cycle.
- A valid bit travels alongside each product.
- The pipeline is never stalled or flushed except by `reset`.

State machine:
- States: IDLE, ACC, DONE.
- IDLE is entered after reset. Products that reach the accumulator stage are dropped.
- `init_acc` in any state does all of the following:
  - loads `out` = sext(`init_value`)
  - latches `num_terms` as the window limit
  - clears the term count and `overflow`
  - goes to ACC, or directly to DONE with an `out_valid` pulse if `num_terms` == 0
- ACC: each valid product leaving the pipeline is added to `out` and increments the count.
  - When the count reaches the limit: go to DONE and pulse `out_valid` in the same cycle `out` shows the final sum.
- DONE: `out` holds. Further arriving products are dropped; `overflow` and count are unchanged.

Arithmetic:
- Sum = `out` + sext(product), computed at OUTW+1 bits.
- Overflow = the sum lies outside [−2^(OUTW−1), 2^(OUTW−1)−1].
- SAT=0: `out` takes the low OUTW bits (wrap).
- SAT=1: `out` takes the clamped extreme.
- `overflow` is set in both modes.

Simultaneous events:
- `reset` overrides everything.
- `init_acc` overrides a product arriving at the accumulator in the same cycle; that product is dropped and not counted.
- Products already inside the pipeline when `init_acc` occurs are accumulated into the new window if they arrive later.

## Timing
- Reset values: `out` = 0, `out_valid` = 0, `overflow` = 0, state IDLE, count 0, all pipeline valids 0.
- Operands presented with `input_valid` in cycle t affect `out` in cycle t+PIPES+1. With PIPES=1 this matches the two-stage MAC.
- `init_acc` in cycle t: `out` = init value in cycle t+1.
  - Earliest operands that count toward the window arrive in cycle t. They land in t+PIPES+1, after the init.
- `out_valid` is registered and high for exactly one cycle, aligned with the final `out`.
  - With num_terms == 0 it is high in cycle t+1 after `init_acc`.
- Back-to-back windows: `init_acc` may be asserted in the same cycle `out_valid` is high. The new window starts next cycle and the completed sum is still visible during the pulse.
- Full throughput: one product per cycle, no bubbles required.

## Test plan
- **Basic window.** Defaults (PIPES=2). `init_acc` with init 5, num_terms 3 in cycle 0; operands (2,3), (−4,5), (7,7) in cycles 0–2. Required: `out` = 40 and `out_valid` = 1 in cycle 5 only; `out` holds 40 afterwards.
- **Drop after done.** After the above, one more valid (10,10). Required: `out` stays 40, no second pulse, state DONE. `init_acc` with init 0, num_terms 1, then (3,3). Required: `out` = 9 with a pulse.
- **Saturation and wrap.** INW=12, OUTW=24, init 0, num_terms 3, operands (2047,2047) ×3.
  - SAT=1: `out` = 8388607 and `overflow` = 1.
  - SAT=0: `out` = −4206589 and `overflow` = 1.
  - Both: `overflow` clears on next `init_acc`.
- **Zero terms and collision.**
  - num_terms 0 with init −7: `out` = −7 and `out_valid` in the cycle after `init_acc`.
  - Separately, assert `init_acc` exactly when a product arrives at the accumulator. Required: product dropped, count unchanged.
- **Reset mid-window.** Reset during ACC with products in flight. Required: next cycle `out` = 0, `out_valid` = 0, state IDLE; in-flight products never accumulate.
- **Pipeline depth sweep.** PIPES=1 and PIPES=4 with streaming back-to-back windows. Required: latency PIPES+1, one pulse per window, and sums match a reference model.
